// File: rtl/run_ctrl.sv
// Load/run sequencer: streams bytes into data memory with the core held in reset,
// then releases the core and counts run cycles until done or timeout.
module run_ctrl #(
  parameter logic [7:0]  LOAD_BASE  = 8'h00,
  parameter int unsigned LOAD_LEN   = 64,
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        dm_we,
  output logic [7:0]  dm_addr,
  output logic [7:0]  dm_din,
  output logic        core_reset,
  input  logic        core_done,
  output logic        busy,
  output logic        finished,
  output logic        timeout,
  output logic [15:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4,
    S_TOUT    = 3'd5
  } state_t;

  localparam logic [8:0]  LAST_IDX  = 9'(LOAD_LEN - 1);
  localparam logic [16:0] LIMIT_EXT = {1'b0, MAX_CYCLES};

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [15:0] cyc_q, cyc_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    in_ready   = 1'b0;
    dm_we      = 1'b0;
    dm_din     = 8'h00;
    core_reset = 1'b1;
    case (state_q)
      S_IDLE, S_DONE, S_TOUT: begin
        if (start) begin
          cnt_d   = '0;
          cyc_d   = '0;
          state_d = (LOAD_LEN == 0) ? S_RELEASE : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dm_we  = 1'b1;
          dm_din = in_data;
          cnt_d  = cnt_q + 9'd1;
          if (cnt_q == LAST_IDX) state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_RUN;
      S_RUN: begin
        core_reset = 1'b0;
        if (cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
        // done takes priority over a coinciding limit
        if (core_done) state_d = S_DONE;
        else if (({1'b0, cyc_q} + 17'd1) >= LIMIT_EXT) state_d = S_TOUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dm_addr     = LOAD_BASE + cnt_q[7:0];
  assign busy        = (state_q == S_LOAD) || (state_q == S_RELEASE) || (state_q == S_RUN);
  assign finished    = (state_q == S_DONE) || (state_q == S_TOUT);
  assign timeout     = (state_q == S_TOUT);
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: expected writes and run endings are queued by
// the stimulus and checked by a monitor when the DUT presents them.
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, in_valid, core_done;
  logic [7:0]  in_data;
  logic        in_ready, dm_we, core_reset, busy, finished, timeout;
  logic [7:0]  dm_addr, dm_din;
  logic [15:0] cycle_count;

  logic        start0;
  logic        in_ready0, dm_we0, core_reset0, busy0, finished0, timeout0;
  logic [7:0]  dm_addr0, dm_din0;
  logic [15:0] cycle_count0;

  int n_tests = 0;
  int n_fail  = 0;
  int we0_pulses = 0;

  logic [15:0] wr_q[$];   // {addr, data}
  logic [16:0] end_q[$];  // {timeout, cycle_count}
  logic        fin_prev = 1'b0;

  always #5 clk = ~clk;

  run_ctrl #(.LOAD_BASE(8'hFE), .LOAD_LEN(4), .MAX_CYCLES(16'd20)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din),
    .core_reset(core_reset), .core_done(core_done), .busy(busy), .finished(finished),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  run_ctrl #(.LOAD_BASE(8'h10), .LOAD_LEN(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .in_valid(1'b1), .in_data(8'h5A),
    .in_ready(in_ready0), .dm_we(dm_we0), .dm_addr(dm_addr0), .dm_din(dm_din0),
    .core_reset(core_reset0), .core_done(1'b0), .busy(busy0), .finished(finished0),
    .timeout(timeout0), .cycle_count(cycle_count0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: writes and run endings
  always @(negedge clk) begin
    if (dm_we0 === 1'b1) we0_pulses++;
    if (dm_we === 1'b1) begin
      if (wr_q.size() == 0) chk("unexpected_write", {16'h0, dm_addr, dm_din}, 32'hFFFF_FFFF);
      else chk("write_addr_data", {16'h0, dm_addr, dm_din}, {16'h0, wr_q.pop_front()});
    end
    if (finished === 1'b1 && !fin_prev) begin
      if (end_q.size() == 0) chk("unexpected_finish", {15'h0, timeout, cycle_count}, 32'hFFFF_FFFF);
      else chk("run_end_tout_count", {15'h0, timeout, cycle_count}, {15'h0, end_q.pop_front()});
      chk("run_end_core_held", {31'h0, core_reset}, 32'd1);
    end
    fin_prev = finished;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1; in_data = b; wr_q.push_back({8'h00, b});
    tick();
    in_valid = 1'b0; in_data = 8'hEE;
  endtask

  task automatic load4(input logic [7:0] b0, b1, b2, b3);
    wr_q.push_back({8'hFE, b0}); wr_q.push_back({8'hFF, b1});
    wr_q.push_back({8'h00, b2}); wr_q.push_back({8'h01, b3});
    in_valid = 1'b1;
    in_data = b0; tick(); in_data = b1; tick();
    in_data = b2; tick(); in_data = b3; tick();
    in_valid = 1'b0; in_data = 8'hEE;
  endtask

  initial begin
    logic [7:0] gap_bytes [4];
    logic       gap_pat   [7];
    int         k;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'hEE; core_done = 1'b0; start0 = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_core_reset", {31'h0, core_reset}, 32'd1);
    chk("rst_in_ready",   {31'h0, in_ready}, 32'd0);
    chk("rst_dm_we",      {31'h0, dm_we}, 32'd0);
    chk("rst_dm_addr",    {24'h0, dm_addr}, 32'hFE);
    chk("rst_dm_din",     {24'h0, dm_din}, 32'h0);
    chk("rst_flags",      {29'h0, busy, finished, timeout}, 32'd0);
    chk("rst_cycle_count", {16'h0, cycle_count}, 32'd0);
    reset = 1'b0;
    tick();

    // back-to-back load, wrap FE..01, run until done on 10th RUN cycle
    pulse_start();
    chk("load_in_ready", {31'h0, in_ready}, 32'd1);
    load4(8'h11, 8'h22, 8'h33, 8'h44);
    chk("release_core_held", {31'h0, core_reset}, 32'd1);
    chk("release_in_ready", {31'h0, in_ready}, 32'd0);
    chk("release_busy", {31'h0, busy}, 32'd1);
    tick();
    chk("run1_core_reset", {31'h0, core_reset}, 32'd0);
    end_q.push_back({1'b0, 16'd10});
    repeat (9) tick();
    core_done = 1'b1; tick(); core_done = 1'b0;
    chk("done_finished", {30'h0, finished, timeout}, 32'b10);
    repeat (2) tick();
    chk("done_count_held", {16'h0, cycle_count}, 32'd10);
    pulse_start();
    chk("restart_count", {16'h0, cycle_count}, 32'd0);
    chk("restart_finished", {31'h0, finished}, 32'd0);
    chk("restart_in_ready", {31'h0, in_ready}, 32'd1);

    // gapped load then timeout after 20 RUN cycles
    gap_bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    gap_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    k = 0;
    for (int i = 0; i < 7; i++) begin
      if (gap_pat[i]) begin
        wr_q.push_back({(8'hFE + 8'(k)), gap_bytes[k]});
        in_valid = 1'b1; in_data = gap_bytes[k]; k++;
      end else begin
        in_valid = 1'b0; in_data = 8'hEE;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("gap_release_core_held", {31'h0, core_reset}, 32'd1);
    tick();
    chk("gap_run_core_reset", {31'h0, core_reset}, 32'd0);
    end_q.push_back({1'b1, 16'd20});
    repeat (25) tick();
    chk("tout_flags", {30'h0, finished, timeout}, 32'b11);
    chk("tout_count_held", {16'h0, cycle_count}, 32'd20);

    // done coincides with limit: done wins
    pulse_start();
    load4(8'h55, 8'h66, 8'h77, 8'h88);
    tick();
    end_q.push_back({1'b0, 16'd20});
    repeat (19) tick();
    core_done = 1'b1; tick(); core_done = 1'b0;
    chk("coincide_timeout", {31'h0, timeout}, 32'd0);

    // reset mid-RUN
    pulse_start();
    load4(8'h01, 8'h02, 8'h03, 8'h04);
    repeat (6) tick();
    chk("midrun_running", {31'h0, core_reset}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrun_rst_core_reset", {31'h0, core_reset}, 32'd1);
    chk("midrun_rst_count", {16'h0, cycle_count}, 32'd0);
    chk("midrun_rst_flags", {29'h0, busy, finished, timeout}, 32'd0);
    tick(); reset = 1'b0; tick();

    // LOAD_LEN=0: straight to RELEASE, start ignored in RUN
    start0 = 1'b1; tick(); start0 = 1'b0;
    chk("len0_release", {29'h0, busy0, core_reset0, in_ready0}, 32'b110);
    tick();
    chk("len0_run", {31'h0, core_reset0}, 32'd0);
    repeat (3) tick();
    start0 = 1'b1; tick(); start0 = 1'b0;
    chk("len0_start_ignored_cr", {31'h0, core_reset0}, 32'd0);
    chk("len0_start_ignored_cnt", {16'h0, cycle_count0}, 32'd4);
    chk("len0_no_writes", we0_pulses, 32'd0);

    tick();
    chk("wr_queue_drained", wr_q.size(), 32'd0);
    chk("end_queue_drained", end_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
